id_exe_reg: RTL

ID_EXE_REG -- requirements
Module: id_exe_reg

---
 rtl/id_exe_reg.sv | 104 ++++++++++
 1 files changed

// File: rtl/id_exe_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_exe_reg
// Purpose  : ID/EXE pipeline register. Captures the decoded instruction on
//            each rising edge, holds it while the pipeline is frozen, and
//            inserts a bubble on reset, flush or an invalid decode slot.
// Revision : 1.0 - initial release
// ============================================================================
module id_exe_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              freeze,

  input  logic              valid_in,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [3:0]        dest_in,
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  input  logic [3:0]        sr_in,

  output logic              valid_out,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic              b_out,
  output logic              s_out,
  output logic [3:0]        exe_cmd_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] val_rn_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic              imm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm_24_out,
  output logic [3:0]        dest_out,
  output logic [3:0]        src1_out,
  output logic [3:0]        src2_out,
  output logic [3:0]        sr_out
);

  // Bubble wins over everything except that a frozen stage with an invalid
  // decode slot must hold, not clear: only an unfrozen empty slot bubbles.
  logic bubble;
  logic load;

  assign bubble = ~rst_n | flush | (~freeze & ~valid_in);
  assign load   = ~freeze & valid_in;

  // Single register bank: bubble clears every field, load captures, else hold.
  always_ff @(posedge clk) begin
    if (bubble) begin
      valid_out         <= 1'b0;
      wb_en_out         <= 1'b0;
      mem_r_en_out      <= 1'b0;
      mem_w_en_out      <= 1'b0;
      b_out             <= 1'b0;
      s_out             <= 1'b0;
      exe_cmd_out       <= 4'b0000;
      pc_out            <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      imm_out           <= 1'b0;
      shift_operand_out <= '0;
      signed_imm_24_out <= '0;
      dest_out          <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
      sr_out            <= '0;
    end else if (load) begin
      valid_out         <= valid_in;
      wb_en_out         <= wb_en_in;
      mem_r_en_out      <= mem_r_en_in;
      mem_w_en_out      <= mem_w_en_in;
      b_out             <= b_in;
      s_out             <= s_in;
      exe_cmd_out       <= exe_cmd_in;
      pc_out            <= pc_in;
      val_rn_out        <= val_rn_in;
      val_rm_out        <= val_rm_in;
      imm_out           <= imm_in;
      shift_operand_out <= shift_operand_in;
      signed_imm_24_out <= signed_imm_24_in;
      dest_out          <= dest_in;
      src1_out          <= src1_in;
      src2_out          <= src2_in;
      sr_out            <= sr_in;
    end
  end

endmodule
`default_nettype wire
